// File: rtl/joypad_pkg.sv
// joypad_pkg
//   Shared definitions for the dual-controller serial joypad reader:
//   - NUM_BUTTONS : number of buttons shifted out by each controller
//   - IDX_W       : width of the bit index that selects a button position
//   - state_t     : read-sequencer state encoding
package joypad_pkg;

  localparam int NUM_BUTTONS = 8;
  localparam int IDX_W       = $clog2(NUM_BUTTONS);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LATCH    = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/joypad_capture.sv
// joypad_capture
//   Per-player capture register. Each write stores the inverted serial bit
//   (the controller line is active-low) at the selected button position,
//   so the parallel output is active-high (1 = pressed).
// Ports
//   clk       : system clock, rising edge
//   reset_i   : synchronous active-high reset, clears all bits
//   wr_en_i   : write strobe for one button bit
//   wr_idx_i  : button position written when wr_en_i is high
//   data_n_i  : serial data from the controller, active-low
//   bits_o    : captured button set, active-high
module joypad_capture
  import joypad_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_i,
  input  logic                   wr_en_i,
  input  logic [IDX_W-1:0]       wr_idx_i,
  input  logic                   data_n_i,
  output logic [NUM_BUTTONS-1:0] bits_o
);

  logic [NUM_BUTTONS-1:0] bits_q;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      bits_q <= '0;
    end else if (wr_en_i) begin
      bits_q[wr_idx_i] <= ~data_n_i;
    end
  end

  assign bits_o = bits_q;

endmodule

// File: rtl/joypad_reader.sv
// joypad_reader
//   Reads two serial game controllers in parallel. A rising edge on start
//   runs one sequence: a latch pulse of two half periods, then eight shift
//   clocks, each a low half period followed by a high half period. Each
//   button is sampled in the last cycle of the low half period. At the end
//   both button sets are published together with a one-cycle valid pulse.
// Ports
//   clk          : system clock, rising edge
//   reset        : synchronous active-high reset
//   start        : poll request, rising edge starts a read (ignored while busy)
//   pad_latch    : parallel-load strobe to both controllers, active-high
//   pad_clk      : shift clock to both controllers, idles high
//   pad_data_p1  : serial data, controller 1, active-low
//   pad_data_p2  : serial data, controller 2, active-low
//   switches_p1  : last complete button set, player 1, active-high
//   switches_p2  : last complete button set, player 2, active-high
//   valid        : one-cycle pulse while the switches hold a fresh result
//   busy         : high from the first latch cycle through the done cycle
module joypad_reader
  import joypad_pkg::*;
#(
  parameter int HALF_PERIOD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       pad_latch,
  output logic       pad_clk,
  input  logic       pad_data_p1,
  input  logic       pad_data_p2,
  output logic [7:0] switches_p1,
  output logic [7:0] switches_p2,
  output logic       valid,
  output logic       busy
);

  localparam logic [7:0]       HP_LOAD  = 8'(HALF_PERIOD - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BUTTONS - 1);

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  // The latch pulse spans two half periods; the counter only holds one,
  // so this flag marks the second half.
  logic                   latch_ph_q, latch_ph_d;
  logic                   start_q;
  logic [7:0]             sw_p1_q, sw_p2_q;
  logic                   sample;
  logic                   start_edge;
  logic                   cnt_zero;
  logic [NUM_BUTTONS-1:0] cap_p1, cap_p2;

  assign start_edge = start & ~start_q;
  assign cnt_zero   = (cnt_q == 8'd0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    latch_ph_d = latch_ph_q;
    sample     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d    = ST_LATCH;
          cnt_d      = HP_LOAD;
          latch_ph_d = 1'b0;
        end
      end
      ST_LATCH: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 8'd1;
        end else if (!latch_ph_q) begin
          latch_ph_d = 1'b1;
          cnt_d      = HP_LOAD;
        end else begin
          state_d = ST_SHIFT_LO;
          idx_d   = '0;
          cnt_d   = HP_LOAD;
        end
      end
      ST_SHIFT_LO: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          sample  = 1'b1;
          state_d = ST_SHIFT_HI;
          cnt_d   = HP_LOAD;
        end
      end
      ST_SHIFT_HI: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 8'd1;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          cnt_d   = HP_LOAD;
        end else begin
          state_d = ST_SHIFT_LO;
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = HP_LOAD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      idx_q      <= '0;
      latch_ph_q <= 1'b0;
      // Held at 1 so a start line that is already high leaving reset
      // is not mistaken for a fresh request.
      start_q    <= 1'b1;
      sw_p1_q    <= 8'h00;
      sw_p2_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      latch_ph_q <= latch_ph_d;
      start_q    <= start;
      // Publish on the edge entering DONE so the switches are already
      // stable during the cycle valid is high.
      if (state_d == ST_DONE) begin
        sw_p1_q <= cap_p1;
        sw_p2_q <= cap_p2;
      end
    end
  end

  joypad_capture u_cap_p1 (
    .clk      (clk),
    .reset_i  (reset),
    .wr_en_i  (sample),
    .wr_idx_i (idx_q),
    .data_n_i (pad_data_p1),
    .bits_o   (cap_p1)
  );

  joypad_capture u_cap_p2 (
    .clk      (clk),
    .reset_i  (reset),
    .wr_en_i  (sample),
    .wr_idx_i (idx_q),
    .data_n_i (pad_data_p2),
    .bits_o   (cap_p2)
  );

  assign pad_latch   = (state_q == ST_LATCH);
  assign pad_clk     = (state_q != ST_SHIFT_LO);
  assign busy        = (state_q != ST_IDLE);
  assign valid       = (state_q == ST_DONE);
  assign switches_p1 = sw_p1_q;
  assign switches_p2 = sw_p2_q;

endmodule

// File: tb/tb_joypad_reader.sv
// tb_joypad_reader
//   Two readers (HALF_PERIOD 4 and 2) share start/reset and the button
//   patterns; each has its own behavioural controller model. Every read is
//   checked for latency, single valid pulse, published buttons, and the
//   latch / shift-clock waveform timing.
module tb_joypad_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] btn_p1, btn_p2;

  logic       pad_latch [2];
  logic       pad_clk   [2];
  logic       dat1      [2];
  logic       dat2      [2];
  logic       valid     [2];
  logic       busy      [2];
  logic [7:0] sw1       [2];
  logic [7:0] sw2       [2];

  int hp [2] = '{4, 2};
  int checks = 0;
  int errors = 0;
  localparam int L = 210;

  always #5 clk = ~clk;

  joypad_reader #(.HALF_PERIOD(4)) dut4 (
    .clk(clk), .reset(reset), .start(start),
    .pad_latch(pad_latch[0]), .pad_clk(pad_clk[0]),
    .pad_data_p1(dat1[0]), .pad_data_p2(dat2[0]),
    .switches_p1(sw1[0]), .switches_p2(sw2[0]),
    .valid(valid[0]), .busy(busy[0])
  );

  joypad_reader #(.HALF_PERIOD(2)) dut2 (
    .clk(clk), .reset(reset), .start(start),
    .pad_latch(pad_latch[1]), .pad_clk(pad_clk[1]),
    .pad_data_p1(dat1[1]), .pad_data_p2(dat2[1]),
    .switches_p1(sw1[1]), .switches_p2(sw2[1]),
    .valid(valid[1]), .busy(busy[1])
  );

  // Controller model: 8-bit shift register loaded (active-low) while the
  // latch is high, shifted on each rising pad_clk, ones shifted in behind.
  logic [7:0] sr1 [2];
  logic [7:0] sr2 [2];
  logic       pclk_prev [2] = '{1'b1, 1'b1};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      pclk_prev[i] <= pad_clk[i];
      if (pad_latch[i]) begin
        sr1[i] <= ~btn_p1;
        sr2[i] <= ~btn_p2;
      end else if (pad_clk[i] && !pclk_prev[i]) begin
        sr1[i] <= {1'b1, sr1[i][7:1]};
        sr2[i] <= {1'b1, sr2[i][7:1]};
      end
    end
  end

  assign dat1[0] = sr1[0][0];
  assign dat2[0] = sr2[0][0];
  assign dat1[1] = sr1[1][0];
  assign dat2[1] = sr2[1][0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One read: start rises now; optionally dropped at lower_at, raised again
  // at raise_at, and reset pulsed at reset_at (cycle counts after the edge).
  task automatic run(input logic [7:0] b1, input logic [7:0] b2,
                     input int lower_at, input int raise_at, input int reset_at,
                     input string tag);
    int vfirst [2];
    int vcnt [2];
    int lat [2];
    int low [2];
    int fall [2];
    int busyc [2];
    int lrun [2];
    int hrun [2];
    logic bad [2];
    logic partial [2];
    logic pc_prev [2];
    logic [7:0] at1 [2];
    logic [7:0] at2 [2];
    logic [7:0] ent1 [2];
    logic [7:0] ent2 [2];
    logic aborted;
    int lat_exp;
    for (int i = 0; i < 2; i++) begin
      vfirst[i] = 0; vcnt[i] = 0; lat[i] = 0; low[i] = 0; fall[i] = 0;
      busyc[i] = 0; lrun[i] = 0; hrun[i] = 0; bad[i] = 1'b0;
      partial[i] = 1'b0; pc_prev[i] = 1'b1; at1[i] = 8'h00; at2[i] = 8'h00;
      ent1[i] = sw1[i]; ent2[i] = sw2[i];
    end
    btn_p1 = b1;
    btn_p2 = b2;
    start  = 1'b1;
    for (int n = 1; n <= L; n++) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (valid[i]) begin
          vcnt[i]++;
          if (vfirst[i] == 0) begin
            vfirst[i] = n; at1[i] = sw1[i]; at2[i] = sw2[i];
          end
        end
        if (vfirst[i] == 0 && (reset_at == 0 || n <= reset_at) &&
            (sw1[i] !== ent1[i] || sw2[i] !== ent2[i]))
          partial[i] = 1'b1;
        if (pad_latch[i]) lat[i]++;
        if (busy[i]) busyc[i]++;
        if (!pad_clk[i]) begin
          if (pc_prev[i]) begin
            fall[i]++;
            if (fall[i] > 1 && hrun[i] != hp[i]) bad[i] = 1'b1;
            lrun[i] = 0;
          end
          lrun[i]++;
          low[i]++;
        end else begin
          if (!pc_prev[i]) begin
            if (lrun[i] != hp[i]) bad[i] = 1'b1;
            hrun[i] = 0;
          end
          hrun[i]++;
        end
        pc_prev[i] = pad_clk[i];
      end
      if (n == lower_at) start = 1'b0;
      if (n == raise_at) start = 1'b1;
      if (reset_at != 0 && n == reset_at) reset = 1'b1;
      if (reset_at != 0 && n == reset_at + 1) begin
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("%s rst_latch h%0d", tag, hp[i]), 32'(pad_latch[i]), 32'd0);
          chk($sformatf("%s rst_clk h%0d", tag, hp[i]), 32'(pad_clk[i]), 32'd1);
          chk($sformatf("%s rst_busy h%0d", tag, hp[i]), 32'(busy[i]), 32'd0);
          chk($sformatf("%s rst_sw1 h%0d", tag, hp[i]), 32'(sw1[i]), 32'h00);
          chk($sformatf("%s rst_sw2 h%0d", tag, hp[i]), 32'(sw2[i]), 32'h00);
        end
      end
    end
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      lat_exp = 18 * hp[i] + 1;
      aborted = (reset_at != 0) && (reset_at < lat_exp);
      chk($sformatf("%s vcount h%0d", tag, hp[i]), 32'(vcnt[i]), aborted ? 32'd0 : 32'd1);
      if (!aborted) begin
        chk($sformatf("%s latency h%0d", tag, hp[i]), 32'(vfirst[i]), 32'(lat_exp));
        chk($sformatf("%s sw1_at_valid h%0d", tag, hp[i]), 32'(at1[i]), 32'(b1));
        chk($sformatf("%s sw2_at_valid h%0d", tag, hp[i]), 32'(at2[i]), 32'(b2));
        chk($sformatf("%s no_partial h%0d", tag, hp[i]), 32'(partial[i]), 32'd0);
        chk($sformatf("%s latch_cycles h%0d", tag, hp[i]), 32'(lat[i]), 32'(2 * hp[i]));
        chk($sformatf("%s clk_pulses h%0d", tag, hp[i]), 32'(fall[i]), 32'd8);
        chk($sformatf("%s clk_low_cycles h%0d", tag, hp[i]), 32'(low[i]), 32'(8 * hp[i]));
        chk($sformatf("%s phase_len h%0d", tag, hp[i]), 32'(bad[i]), 32'd0);
        chk($sformatf("%s busy_cycles h%0d", tag, hp[i]), 32'(busyc[i]), 32'(lat_exp));
      end
      chk($sformatf("%s final_sw1 h%0d", tag, hp[i]), 32'(sw1[i]), (reset_at != 0) ? 32'h00 : 32'(b1));
      chk($sformatf("%s final_sw2 h%0d", tag, hp[i]), 32'(sw2[i]), (reset_at != 0) ? 32'h00 : 32'(b2));
      chk($sformatf("%s idle_clk h%0d", tag, hp[i]), 32'(pad_clk[i]), 32'd1);
      chk($sformatf("%s idle_latch h%0d", tag, hp[i]), 32'(pad_latch[i]), 32'd0);
    end
    $display("read %s p1=%02h p2=%02h valid_at h4=%0d h2=%0d", tag, b1, b2, vfirst[0], vfirst[1]);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b1;
    btn_p1 = 8'h00;
    btn_p2 = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset latch h%0d", hp[i]), 32'(pad_latch[i]), 32'd0);
      chk($sformatf("reset clk h%0d", hp[i]), 32'(pad_clk[i]), 32'd1);
      chk($sformatf("reset valid h%0d", hp[i]), 32'(valid[i]), 32'd0);
      chk($sformatf("reset busy h%0d", hp[i]), 32'(busy[i]), 32'd0);
      chk($sformatf("reset sw1 h%0d", hp[i]), 32'(sw1[i]), 32'h00);
      chk($sformatf("reset sw2 h%0d", hp[i]), 32'(sw2[i]), 32'h00);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk($sformatf("start_high_thru_reset busy h%0d", hp[i]), 32'(busy[i]), 32'd0);
    start = 1'b0;
    repeat (2) @(negedge clk);

    run(8'hA5, 8'h3C, 3, 0, 0, "basic");
    run(8'h81, 8'h7E, 2, 20, 0, "retrigger");
    run(8'h5A, 8'hC3, 3, 0, 40, "reset_mid");
    run(8'h96, 8'h0F, 3, 0, 0, "after_reset");
    run(8'h12, 8'h34, 0, 0, 0, "hold_high");
    run(8'hE7, 8'h18, 3, 0, 0, "second_read");
    run(8'hFF, 8'hFF, 3, 0, 0, "all_pressed");
    for (int k = 0; k < 4; k++)
      run(8'($urandom), 8'($urandom), 3, 0, 0, $sformatf("rand%0d", k));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
